regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
- Controller in front of the 32x32 register file.
- Tracks outstanding register writes in a per-register scoreboard and stalls issue on RAW hazards or counter saturation.
- Arbitrates two writeback sources (ALU and memory) onto the register file's single write port.
- Drives the register file's write_add, z5_output and write_enable, and the issue-stage stall.

Parameters:
- NREG, 32, number of architectural registers; must be a power of two.
- AW, 5, register address width, equal to log2(NREG).
- DW, 32, data width.
- CW, 2, width of each pending-write counter; maximum outstanding writes per register is 2^CW-1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- issue_valid  input  1  instruction presented at issue.
- issue_rs1  input  AW  source register 1 address.
- issue_rs2  input  AW  source register 2 address.
- issue_rd  input  AW  destination register address.
- issue_wr  input  1  instruction will write issue_rd.
- issue_stall  output  1  combinational; issue must hold this cycle.
- alu_valid  input  1  ALU writeback request.
- alu_add  input  AW  ALU destination register.
- alu_data  input  DW  ALU result.
- alu_ready  output  1  combinational grant to the ALU.
- mem_valid  input  1  memory writeback request.
- mem_add  input  AW  memory destination register.
- mem_data  input  DW  load data.
- mem_ready  output  1  combinational grant to memory.
- write_add  output  AW  to register file write address.
- z5_output  output  DW  to register file write data.
- write_enable  output  1  to register file write enable.
- sb_error  output  1  sticky; a writeback targeted a register whose pending count was 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - All counters cleared to 0.
  - write_enable=0, write_add=0, z5_output=0, sb_error=0.
  - last_grant=MEM, so the ALU wins the first tie.
  - Reset applied mid-operation discards any registered write that has not yet been presented.
- Register 0 is an ordinary register; no special casing.
- Hazard stall:
  - issue_stall = issue_valid & (cnt[rs1]!=0 | cnt[rs2]!=0 | (issue_wr & cnt[rd]==2^CW-1)).
  - issue_stall is 0 when issue_valid=0.
- Issue accept: issue_valid & !issue_stall & issue_wr increments cnt[issue_rd] at the clock edge.
- Arbitration (combinational):
  - Only one of alu_valid/mem_valid set: that source is granted.
  - Both set: the source not equal to last_grant is granted (round-robin).
  - At most one ready is high per cycle; the ready outputs never assert without the matching valid.
  - A source holds valid, add and data stable until it sees ready.
- Write pipeline, one register stage:
  - On the grant edge: write_add, z5_output <= granted add/data; write_enable <= 1; last_grant updates.
  - No grant: write_enable <= 0; write_add and z5_output hold their values.
  - The register file commits on the following edge.
- Scoreboard decrement:
  - On any edge with write_enable=1, cnt[write_add] decrements, i.e. the same edge the register file commits.
  - issue_stall for that register therefore drops one cycle after commit, so the register file's synchronous read returns the new value.
- Simultaneous events and boundaries:
  - Increment and decrement of the same register on one edge: net 0.
  - Decrement with cnt==0: cnt stays 0, sb_error <= 1 and is held until reset.
  - Increment never exceeds 2^CW-1 because the stall condition prevents it.
- Latency:
  - Grant to write_enable: 1 cycle.
  - Grant to register file update: 2 edges.
  - Grant to stall release: 2 cycles.

Test Plan:
- Reset then idle:
  - Drive reset=0 mid-run with write_enable=1 pending.
  - Required: write_enable=0, issue_stall=0 immediately (asynchronous), all counters 0, sb_error=0.
- RAW stall:
  - Issue rd=5, wr=1, then issue rs1=5: issue_stall=1.
  - alu_valid, alu_add=5, alu_data=0x1234 granted at edge N: write_enable=1 after N.
  - Required: issue_stall stays 1 through edge N+1 and drops after it; the next read of r5 returns 0x1234.
- Arbitration tie:
  - alu_valid and mem_valid held with adds 3 and 4.
  - Required: cycle 1 alu_ready=1; cycle 2 mem_ready=1; write_add sequence 3 then 4 with write_enable continuously 1.
- Saturation:
  - Issue three writes to rd=7 (CW=2); a fourth issue with rd=7 gets issue_stall=1.
  - Retire one write to 7: the fourth issue is accepted the cycle after the commit.
- Simultaneous increment/decrement:
  - cnt[9]=1; on one edge, issue rd=9 is accepted while write_enable=1 with write_add=9.
  - Required: cnt[9] remains 1 and a later rs1=9 still stalls.
- Spurious writeback:
  - mem writeback to rd=12 with cnt[12]=0.
  - Required: the register file is still written, sb_error=1 one edge after write_enable and stays 1 until reset.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler for the 32x32 register file: per-register pending-write scoreboard,
// RAW/saturation issue stall, and round-robin ALU/memory arbitration onto one write port.
module regfile_wb_scheduler #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int CW   = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rs1,
  input  logic [AW-1:0] issue_rs2,
  input  logic [AW-1:0] issue_rd,
  input  logic          issue_wr,
  output logic          issue_stall,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_add,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_add,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  output logic [AW-1:0] write_add,
  output logic [DW-1:0] z5_output,
  output logic          write_enable,
  output logic          sb_error
);

  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [0:0]    GRANT_ALU = 1'b0;
  localparam logic [0:0]    GRANT_MEM = 1'b1;

  logic [CW-1:0] cnt_arr [NREG];
  logic [0:0]    last_grant_reg;
  logic          write_enable_reg;
  logic [AW-1:0] write_add_reg;
  logic [DW-1:0] z5_output_reg;
  logic          sb_error_reg;
  logic          issue_accept;

  assign issue_stall = issue_valid &
                       ((cnt_arr[issue_rs1] != '0) |
                        (cnt_arr[issue_rs2] != '0) |
                        (issue_wr & (cnt_arr[issue_rd] == CNT_MAX)));

  assign issue_accept = issue_valid & ~issue_stall & issue_wr;

  // On a tie the source that did not win last time is granted.
  assign alu_ready = alu_valid & (~mem_valid | (last_grant_reg == GRANT_MEM));
  assign mem_ready = mem_valid & (~alu_valid | (last_grant_reg == GRANT_ALU));

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_cnt
      logic [CW-1:0] cnt_reg;
      logic          inc;
      logic          dec;

      assign inc = issue_accept & (issue_rd == AW'(gi));
      // Decrement on the same edge the register file commits the write.
      assign dec = write_enable_reg & (write_add_reg == AW'(gi)) & (cnt_reg != '0);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_reg <= '0;
        end else if (inc & ~dec) begin
          cnt_reg <= cnt_reg + 1'b1;
        end else if (dec & ~inc) begin
          cnt_reg <= cnt_reg - 1'b1;
        end
      end

      assign cnt_arr[gi] = cnt_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_enable_reg <= 1'b0;
      write_add_reg    <= '0;
      z5_output_reg    <= '0;
      last_grant_reg   <= GRANT_MEM;
      sb_error_reg     <= 1'b0;
    end else begin
      write_enable_reg <= alu_ready | mem_ready;
      if (alu_ready) begin
        write_add_reg  <= alu_add;
        z5_output_reg  <= alu_data;
        last_grant_reg <= GRANT_ALU;
      end else if (mem_ready) begin
        write_add_reg  <= mem_add;
        z5_output_reg  <= mem_data;
        last_grant_reg <= GRANT_MEM;
      end
      if (write_enable_reg && (cnt_arr[write_add_reg] == '0)) begin
        sb_error_reg <= 1'b1;
      end
    end
  end

  assign write_enable = write_enable_reg;
  assign write_add    = write_add_reg;
  assign z5_output    = z5_output_reg;
  assign sb_error     = sb_error_reg;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Randomized and directed bench for regfile_wb_scheduler against a behavioural scoreboard model.
module tb_regfile_wb_scheduler;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          issue_valid = 1'b0;
  logic [AW-1:0] issue_rs1 = '0;
  logic [AW-1:0] issue_rs2 = '0;
  logic [AW-1:0] issue_rd = '0;
  logic          issue_wr = 1'b0;
  logic          issue_stall;
  logic          alu_valid = 1'b0;
  logic [AW-1:0] alu_add = '0;
  logic [DW-1:0] alu_data = '0;
  logic          alu_ready;
  logic          mem_valid = 1'b0;
  logic [AW-1:0] mem_add = '0;
  logic [DW-1:0] mem_data = '0;
  logic          mem_ready;
  logic [AW-1:0] write_add;
  logic [DW-1:0] z5_output;
  logic          write_enable;
  logic          sb_error;

  always #5 clk = ~clk;

  regfile_wb_scheduler #(.NREG(NREG), .AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_wr(issue_wr), .issue_stall(issue_stall),
    .alu_valid(alu_valid), .alu_add(alu_add), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_add(mem_add), .mem_data(mem_data), .mem_ready(mem_ready),
    .write_add(write_add), .z5_output(z5_output), .write_enable(write_enable),
    .sb_error(sb_error)
  );

  // Register file sitting behind the scheduler's write port.
  logic [DW-1:0] rf [NREG];
  always @(posedge clk) if (write_enable) rf[write_add] <= z5_output;

  int total = 0;
  int bad = 0;

  // Model state: plain outstanding-write counts plus the expected write stage.
  int            m_cnt [NREG];
  bit            m_last_mem;
  bit            m_we;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  bit            m_err;
  bit            e_stall, e_ar, e_mr;

  int unassigned [NREG];
  bit alu_busy, mem_busy;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_cnt[i] = 0;
      unassigned[i] = 0;
    end
    m_last_mem = 1'b1;
    m_we = 1'b0;
    m_wa = '0;
    m_wd = '0;
    m_err = 1'b0;
    alu_busy = 1'b0;
    mem_busy = 1'b0;
  endtask

  task automatic model_comb();
    e_stall = issue_valid && (m_cnt[issue_rs1] > 0 || m_cnt[issue_rs2] > 0 ||
                              (issue_wr && m_cnt[issue_rd] == CMAX));
    if (alu_valid && mem_valid) begin
      e_ar = m_last_mem;
      e_mr = !m_last_mem;
    end else begin
      e_ar = alu_valid;
      e_mr = mem_valid;
    end
  endtask

  task automatic model_edge();
    model_comb();
    if (m_we) begin
      if (m_cnt[m_wa] == 0) m_err = 1'b1;
      else m_cnt[m_wa] = m_cnt[m_wa] - 1;
    end
    if (issue_valid && !e_stall && issue_wr) m_cnt[issue_rd] = m_cnt[issue_rd] + 1;
    if (e_ar) begin
      m_we = 1'b1; m_wa = alu_add; m_wd = alu_data; m_last_mem = 1'b0;
    end else if (e_mr) begin
      m_we = 1'b1; m_wa = mem_add; m_wd = mem_data; m_last_mem = 1'b1;
    end else begin
      m_we = 1'b0;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_comb();
    check_eq("stall", 32'(issue_stall), 32'(e_stall));
    check_eq("alu_ready", 32'(alu_ready), 32'(e_ar));
    check_eq("mem_ready", 32'(mem_ready), 32'(e_mr));
    check_eq("write_enable", 32'(write_enable), 32'(m_we));
    check_eq("write_add", 32'(write_add), 32'(m_wa));
    check_eq("z5_output", z5_output, m_wd);
    check_eq("sb_error", 32'(sb_error), 32'(m_err));
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic set_issue(input bit v, input int rs1, input int rs2, input int rd, input bit wr);
    issue_valid = v;
    issue_rs1 = AW'(rs1);
    issue_rs2 = AW'(rs2);
    issue_rd = AW'(rd);
    issue_wr = wr;
  endtask

  // Reset is asserted mid-cycle with current inputs still applied.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_eq("rst_we", 32'(write_enable), 32'd0);
    check_eq("rst_stall", 32'(issue_stall), 32'd0);
    check_eq("rst_err", 32'(sb_error), 32'd0);
    check_eq("rst_wa", 32'(write_add), 32'd0);
    issue_valid = 1'b0;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();

    // Reset while a write is registered and a RAW hazard is being presented
    set_issue(1, 0, 0, 5, 1);
    cyc();
    set_issue(1, 5, 0, 0, 0);
    alu_valid = 1'b1; alu_add = 5'd5; alu_data = 32'hAAAA;
    sample();
    check_eq("pre_rst_stall", 32'(issue_stall), 32'd1);
    advance();
    alu_valid = 1'b0;
    sample();
    check_eq("pre_rst_we", 32'(write_enable), 32'd1);
    do_reset();
    for (int i = 0; i < NREG; i++) begin
      set_issue(1, i, i, i, 0);
      cyc();
    end

    // RAW stall and release two cycles after grant
    set_issue(1, 0, 0, 5, 1);
    cyc();
    set_issue(1, 5, 0, 0, 0);
    alu_valid = 1'b1; alu_add = 5'd5; alu_data = 32'h1234;
    sample();
    check_eq("raw_stall0", 32'(issue_stall), 32'd1);
    check_eq("raw_grant", 32'(alu_ready), 32'd1);
    advance();
    alu_valid = 1'b0;
    sample();
    check_eq("raw_we", 32'(write_enable), 32'd1);
    check_eq("raw_stall1", 32'(issue_stall), 32'd1);
    advance();
    sample();
    check_eq("raw_release", 32'(issue_stall), 32'd0);
    check_eq("raw_rf5", rf[5], 32'h1234);
    advance();
    issue_valid = 1'b0;

    // Arbitration tie right after reset: ALU first, then memory
    do_reset();
    set_issue(1, 0, 0, 3, 1);
    cyc();
    set_issue(1, 0, 0, 4, 1);
    cyc();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_add = 5'd3; alu_data = 32'h33;
    mem_valid = 1'b1; mem_add = 5'd4; mem_data = 32'h44;
    sample();
    check_eq("tie_alu", 32'(alu_ready), 32'd1);
    check_eq("tie_mem_lo", 32'(mem_ready), 32'd0);
    advance();
    alu_valid = 1'b0;
    sample();
    check_eq("tie_mem", 32'(mem_ready), 32'd1);
    check_eq("tie_wa3", 32'(write_add), 32'd3);
    check_eq("tie_we1", 32'(write_enable), 32'd1);
    advance();
    mem_valid = 1'b0;
    sample();
    check_eq("tie_wa4", 32'(write_add), 32'd4);
    check_eq("tie_we2", 32'(write_enable), 32'd1);
    advance();
    cyc();
    cyc();

    // Counter saturation on r7
    for (int i = 0; i < CMAX; i++) begin
      set_issue(1, 0, 0, 7, 1);
      cyc();
    end
    sample();
    check_eq("sat_stall", 32'(issue_stall), 32'd1);
    advance();
    alu_valid = 1'b1; alu_add = 5'd7; alu_data = 32'h77;
    sample();
    check_eq("sat_stall_g", 32'(issue_stall), 32'd1);
    advance();
    alu_valid = 1'b0;
    sample();
    check_eq("sat_stall_we", 32'(issue_stall), 32'd1);
    advance();
    sample();
    check_eq("sat_accept", 32'(issue_stall), 32'd0);
    advance();
    sample();
    check_eq("sat_full_again", 32'(issue_stall), 32'd1);
    advance();
    issue_valid = 1'b0;

    // Increment and decrement of r9 on the same edge
    set_issue(1, 0, 0, 9, 1);
    cyc();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_add = 5'd9; alu_data = 32'h99;
    cyc();
    alu_valid = 1'b0;
    set_issue(1, 0, 0, 9, 1);
    sample();
    check_eq("simul_we", 32'(write_enable), 32'd1);
    check_eq("simul_wa", 32'(write_add), 32'd9);
    check_eq("simul_nostall", 32'(issue_stall), 32'd0);
    advance();
    set_issue(1, 9, 0, 0, 0);
    sample();
    check_eq("simul_still_busy", 32'(issue_stall), 32'd1);
    advance();
    issue_valid = 1'b0;
    cyc();

    // Randomized traffic; writebacks only target registers with outstanding writes
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) do_reset();
      set_issue($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 1));
      if (!alu_busy && $urandom_range(0, 2) == 0) begin
        int s = $urandom_range(0, NREG - 1);
        for (int k = 0; k < NREG; k++) begin
          int r = (s + k) % NREG;
          if (!alu_busy && unassigned[r] > 0) begin
            unassigned[r]--;
            alu_busy = 1'b1;
            alu_valid = 1'b1; alu_add = AW'(r); alu_data = $urandom;
          end
        end
      end
      if (!mem_busy && $urandom_range(0, 2) == 0) begin
        int s = $urandom_range(0, NREG - 1);
        for (int k = 0; k < NREG; k++) begin
          int r = (s + k) % NREG;
          if (!mem_busy && unassigned[r] > 0) begin
            unassigned[r]--;
            mem_busy = 1'b1;
            mem_valid = 1'b1; mem_add = AW'(r); mem_data = $urandom;
          end
        end
      end
      sample();
      if (issue_valid && !e_stall && issue_wr) unassigned[issue_rd]++;
      advance();
      if (e_ar) begin alu_valid = 1'b0; alu_busy = 1'b0; end
      if (e_mr) begin mem_valid = 1'b0; mem_busy = 1'b0; end
    end
    issue_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cyc();
      if (e_ar) begin alu_valid = 1'b0; alu_busy = 1'b0; end
      if (e_mr) begin mem_valid = 1'b0; mem_busy = 1'b0; end
    end

    // Spurious memory writeback to r12 (never issued)
    alu_valid = 1'b0;
    mem_valid = 1'b1; mem_add = 5'd12; mem_data = 32'hC0DE;
    sample();
    check_eq("spur_grant", 32'(mem_ready), 32'd1);
    advance();
    mem_valid = 1'b0;
    sample();
    check_eq("spur_we", 32'(write_enable), 32'd1);
    check_eq("spur_err0", 32'(sb_error), 32'd0);
    advance();
    sample();
    check_eq("spur_err1", 32'(sb_error), 32'd1);
    check_eq("spur_rf12", rf[12], 32'hC0DE);
    advance();
    for (int c = 0; c < 4; c++) cyc();
    check_eq("spur_err_sticky", 32'(sb_error), 32'd1);
    do_reset();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
